// File: rtl/dct8_pipe.sv
// dct8_pipe: 4-stage 8-point 1-D forward DCT with optional level shift, output
// saturation and a global valid/ready stall.
module dct8_pipe #(
  parameter int IW = 8,
  parameter int OW = 12,
  parameter int CB = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready_in,
  input  logic            i_level_shift,
  input  logic [8*IW-1:0] i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [8*OW-1:0] o_data,
  output logic [7:0]      o_sat
);
  localparam int ACCW = IW + CB + 5;
  localparam int EW = IW + 2;
  localparam logic [IW:0] XOFF = (IW+1)'(2 ** (IW - 1));
  localparam logic signed [ACCW-1:0] RND = ACCW'(2 ** (CB - 1));
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(2 ** (OW - 1) - 1);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(-(2 ** (OW - 1)));

  function automatic real cos16(int m);
    case (m)
      0: return 1.0;
      1: return 0.9807852804032304;
      2: return 0.9238795325112867;
      3: return 0.8314696123025452;
      4: return 0.7071067811865476;
      5: return 0.5555702330196022;
      6: return 0.3826834323650898;
      7: return 0.19509032201612825;
      default: return 0.0;
    endcase
  endfunction

  // cos((2n+1)k*pi/16) folded onto the first quadrant, scaled and rounded half away from zero
  function automatic int coef(int k, int n);
    int  m;
    real c, r;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    c = (m > 8) ? -cos16(16 - m) : cos16(m);
    r = ((k == 0) ? 0.35355339059327373 : 0.5) * c * real'(1 << CB);
    return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(0.5 - r));
  endfunction

  logic                   adv;
  logic                   v1_q, v2_q, v3_q;
  logic signed [IW:0]     xs [8];
  logic signed [EW-1:0]   e_d [4], o_d [4], e_q [4], o_q [4];
  logic signed [ACCW-1:0] p_d [8][4], p_q [8][4];
  logic signed [ACCW-1:0] a_d [8], a_q [8];
  logic [8*OW-1:0]        data_d;
  logic [7:0]             sat_d;

  assign adv = !o_valid || i_ready;
  assign o_ready_in = adv;

  always_comb begin
    for (int n = 0; n < 8; n++)
      xs[n] = i_level_shift ? {1'b0, i_data[n*IW +: IW]} - XOFF : {i_data[n*IW+IW-1], i_data[n*IW +: IW]};
    for (int n = 0; n < 4; n++) begin
      e_d[n] = EW'(xs[n]) + EW'(xs[7-n]);
      o_d[n] = EW'(xs[n]) - EW'(xs[7-n]);
    end
  end

  // even rows are symmetric in n, odd rows antisymmetric, so 4 taps per row suffice
  for (genvar k = 0; k < 8; k++) begin : g_k
    for (genvar n = 0; n < 4; n++) begin : g_n
      localparam logic signed [ACCW-1:0] CK = ACCW'(coef(k, n));
      assign p_d[k][n] = CK * ACCW'((k % 2 == 0) ? e_q[n] : o_q[n]);
    end
    logic signed [ACCW-1:0] r;
    assign a_d[k] = p_q[k][0] + p_q[k][1] + p_q[k][2] + p_q[k][3];
    assign r = (a_q[k] + RND) >>> CB;
    assign sat_d[k] = (r > MAXV) || (r < MINV);
    assign data_d[k*OW +: OW] = (r > MAXV) ? MAXV[OW-1:0] : (r < MINV) ? MINV[OW-1:0] : r[OW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      e_q     <= '{default: '0};
      o_q     <= '{default: '0};
      p_q     <= '{default: '{default: '0}};
      a_q     <= '{default: '0};
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= '0;
    end else if (adv) begin
      v1_q    <= i_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      e_q     <= e_d;
      o_q     <= o_d;
      p_q     <= p_d;
      a_q     <= a_d;
      o_valid <= v3_q;
      o_data  <= data_d;
      o_sat   <= sat_d;
    end
  end
endmodule

// File: tb/tb_dct8_pipe.sv
// tb_dct8_pipe: directed and random checks of dct8_pipe (OW=12 and OW=9 instances)
// against a floating-point-derived 8-term DCT model and a FIFO scoreboard.
module tb_dct8_pipe;
  logic        clk = 1'b0;
  logic        rst, iv, sh, ir;
  logic [63:0] d;
  logic        ordy, ov, ordy9, ov9;
  logic [95:0] od;
  logic [71:0] od9;
  logic [7:0]  os, os9;

  typedef struct {logic [63:0] d; logic sh;} vec_t;
  vec_t        q[$];
  longint      cm [8][8];
  int          total = 0, bad = 0;
  logic        stall_q, acc_f;
  logic [95:0] hold_d;
  logic [7:0]  hold_s;
  logic [63:0] sv [20];
  int          idx, c;

  always #5 clk = ~clk;

  dct8_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready_in(ordy), .i_level_shift(sh),
    .i_data(d), .o_valid(ov), .i_ready(ir), .o_data(od), .o_sat(os)
  );

  dct8_pipe #(.OW(9)) dut9 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready_in(ordy9), .i_level_shift(sh),
    .i_data(d), .o_valid(ov9), .i_ready(ir), .o_data(od9), .o_sat(os9)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint ymodel(input logic [63:0] v, input logic s, input int k);
    longint acc = 0;
    for (int n = 0; n < 8; n++)
      acc += cm[k][n] * (s ? longint'(v[n*8 +: 8]) - 128 : longint'($signed(v[n*8 +: 8])));
    return (acc + 2048) >>> 12;
  endfunction

  function automatic longint clip(input longint y, input int ow);
    longint hi = (longint'(1) << (ow - 1)) - 1;
    return (y > hi) ? hi : (y < -hi - 1) ? -hi - 1 : y;
  endfunction

  task automatic pop_check();
    vec_t        e;
    logic [95:0] e12;
    logic [71:0] e9;
    logic [7:0]  s12, s9;
    longint      y, c12, c9;
    if (q.size() == 0) begin
      chk("spurious_out", ov, 1'b0);
      return;
    end
    e = q.pop_front();
    for (int k = 0; k < 8; k++) begin
      y = ymodel(e.d, e.sh, k);
      c12 = clip(y, 12);
      c9 = clip(y, 9);
      e12[k*12 +: 12] = c12[11:0];
      e9[k*9 +: 9] = c9[8:0];
      s12[k] = (c12 != y);
      s9[k] = (c9 != y);
    end
    chk("coef", od, e12);
    chk("sat", os, s12);
    chk("coef9", od9, e9);
    chk("sat9", os9, s9);
  endtask

  task automatic cyc(input logic v, input logic s, input logic [63:0] dat, input logic r);
    iv = v; sh = s; d = dat; ir = r;
    #1;
    if (stall_q) begin
      chk("hold_valid", ov, 1'b1);
      chk("hold_data", od, hold_d);
      chk("hold_sat", os, hold_s);
    end
    chk("ready_in", ordy, !(ov && !ir));
    chk("valid9", ov9, ov);
    acc_f = iv && ordy;
    if (acc_f) q.push_back(vec_t'{dat, s});
    if (ov && ir) pop_check();
    stall_q = ov && !ir;
    hold_d = od;
    hold_s = os;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; iv = 1'b1; sh = 1'($urandom); d = {$urandom, $urandom}; ir = 1'($urandom);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_valid", ov, 1'b0);
      chk("rst_data", od, 96'd0);
      chk("rst_sat", os, 8'd0);
    end
    rst = 1'b0; iv = 1'b0; ir = 1'b1;
    q.delete();
    stall_q = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", ov, 1'b0);
    chk("post_rst_data", od, 96'd0);
    chk("post_rst_sat", os, 8'd0);
  endtask

  task automatic one(input logic s, input logic [63:0] v);
    cyc(1'b1, s, v, 1'b1);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    chk("latency_early", ov, 1'b0);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    chk("latency", ov, 1'b1);
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; sh = 1'b0; d = '0; ir = 1'b1; stall_q = 1'b0; acc_f = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        real r;
        r = 4096.0 * ((k == 0) ? $sqrt(0.125) : 0.5) * $cos((2 * n + 1) * k * 3.141592653589793 / 16.0);
        cm[k][n] = (r >= 0.0) ? longint'($floor(r + 0.5)) : -longint'($floor(0.5 - r));
      end
    do_reset();

    one(1'b0, {8{8'd100}});
    chk("dc_y0", od[11:0], 12'd283);
    chk("dc_rest", od[95:12], 84'd0);
    chk("dc_sat", os, 8'd0);
    chk("dc9_y0", od9[8:0], 9'd255);
    chk("dc9_rest", od9[71:9], 63'd0);
    chk("dc9_sat", os9, 8'h01);

    one(1'b1, {8{8'd255}});
    chk("ls_on_y0", od[11:0], 12'd359);
    chk("ls_on_rest", od[95:12], 84'd0);

    one(1'b0, {8{8'd255}});
    chk("ls_off_y0", od[11:0], 12'hFFD);
    chk("ls_off_rest", od[95:12], 84'd0);

    one(1'b0, 64'h40);
    chk("imp_y0", od[11:0], 12'd23);
    chk("imp_y1", od[23:12], 12'd31);

    one(1'b0, {8{8'h80}});
    chk("neg_y0", od[11:0], 12'hE96);
    chk("neg_sat", os, 8'd0);
    chk("neg9_y0", od9[8:0], 9'h100);
    chk("neg9_sat", os9, 8'h01);

    for (int i = 0; i < 20; i++) sv[i] = {$urandom, $urandom};
    idx = 0; c = 0;
    while (idx < 20 && c < 300) begin
      cyc(1'b1, 1'b0, sv[idx], (c >= 8 && c < 11) ? 1'b0 : (c < 11) ? 1'b1 : ($urandom_range(0, 2) != 0));
      if (acc_f) idx++;
      c++;
    end
    chk("stream_count", idx, 20);

    repeat (10000)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0);

    c = 0;
    while (q.size() != 0 && c < 50) begin
      cyc(1'b0, 1'b0, 64'd0, 1'b1);
      c++;
    end
    chk("drain_empty", q.size(), 0);

    repeat (6) cyc(1'b1, 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 1) != 0);
    do_reset();
    repeat (6) begin
      cyc(1'b0, 1'b0, 64'd0, 1'b1);
      chk("no_stale", ov, 1'b0);
    end

    one(1'b0, {8{8'd100}});
    chk("post_rst_dc_y0", od[11:0], 12'd283);
    cyc(1'b0, 1'b0, 64'd0, 1'b1);
    chk("final_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dct8_pipe.md
Name: dct8_pipe

Overview:
- Parametrised 8-point 1-D forward DCT engine, generalising the fixed 8-bit/12-bit column DCT.
- Takes one 8-sample vector per cycle and produces eight orthonormal DCT coefficients in natural frequency order.
- Supports programmable input, output and coefficient widths, optional per-vector level shift, saturation with flagging, and valid/ready backpressure.
- Sits between the block/line buffer and the transpose buffer; two instances (row and column) form a 2-D DCT.

Parameters:
- IW, 8: input sample width.
- OW, 12: output coefficient width, signed.
- CB, 12: coefficient fractional bits.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input vector valid.
- o_ready_in  out  1  block can accept input this cycle.
- i_level_shift  in  1  when 1, treat lanes as unsigned and subtract 2^(IW-1); sampled with the vector.
- i_data  in  8*IW  lane n at [n*IW +: IW]; signed when i_level_shift=0.
- o_valid  out  1  output vector valid.
- i_ready  in  1  downstream accepts output.
- o_data  out  8*OW  coefficient k at [k*OW +: OW], signed.
- o_sat  out  8  bit k set if coefficient k was clipped.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset:
  - All stage valids, data registers, o_data and o_sat are cleared to 0; o_valid=0.
  - Reset asserted mid-operation discards all in-flight vectors. No output appears for them after reset deasserts.
- Maths:
  - Coefficient table: C[k][n] = round(2^CB * s(k) * cos((2n+1)kπ/16)), with s(0)=sqrt(1/8) and s(k>0)=1/2. Round half away from zero; table is constant, computed at elaboration.
  - Pre-shift sample: x'[n] = x[n] - 2^(IW-1) when level shift is on (x unsigned), else x[n] signed.
  - Accumulator: acc[k] = Σn C[k][n]·x'[n], held at ACCW = IW+CB+5 bits; no intermediate truncation.
  - Result: y[k] = (acc[k] + 2^(CB-1)) >>> CB, i.e. round half toward +∞ via arithmetic shift.
  - Saturation: if y[k] > 2^(OW-1)-1 or y[k] < -2^(OW-1), clip to that bound and set o_sat[k]=1; else o_sat[k]=0.
- Pipeline, 4 registered stages; latency is 4 cycles from an accepted input to o_valid when there is no stall:
  - S1: level shift, then butterflies e[n]=x'[n]+x'[7-n] and o[n]=x'[n]-x'[7-n] for n=0..3.
  - S2: constant multiplies; even k uses e, odd k uses o, via the symmetry of C.
  - S3: 4-input adder trees per k.
  - S4: round and saturate into the output registers.
- Handshake:
  - Global stall: advance = !o_valid || i_ready, and o_ready_in = advance.
  - Input is accepted when i_valid && o_ready_in.
  - While stalled, every stage holds its data and valid; o_data and o_sat stay stable while o_valid && !i_ready.
  - Bubbles propagate as valid=0 stages. No vector is dropped or duplicated.
  - Sustained throughput is 1 vector per cycle when i_ready=1.
- Simultaneous input accept and output consume in the same cycle are both honoured.
- o_ready_in is combinational from o_valid and i_ready only, not from i_valid.

Test Plan:
- Reset check: pulse i_rst for 2 cycles with garbage inputs -> o_valid=0, o_data=0, o_sat=0 during reset and on the cycle after.
- DC vector: all lanes =100, shift off, defaults -> 4 cycles later y[0]=283, y[1..7]=0, o_sat=0.
- Level shift: all lanes =255, shift on -> y[0]=359, y[1..7]=0. Same vector with shift off (lanes read as -1) -> y[0]=-3, others 0.
- Impulse: lane0=64, others 0, shift off -> y[0]=23 (64·1448/4096=22.6), y[1]=31 (C[1][0]=2009). Remaining y[k] must match a reference model bit-exactly; also run 10k random vectors against the model.
- Saturation: OW=9, all lanes =100 -> y[0]=255 with o_sat=8'h01. Any lane set to -128 with IW=8 must not wrap.
- Backpressure: stream 20 back-to-back vectors, drive i_ready low for 3 cycles mid-stream and randomly thereafter.
  - Required: outputs in order, none lost or duplicated, o_data stable while stalled, o_ready_in=0 exactly when o_valid && !i_ready.
  - Assert i_rst mid-stream -> no stale outputs afterwards.
